// File: rtl/muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider on a shared 2*WIDTH accumulator.
// Operands are reduced to magnitudes up front; one FIX cycle restores result signs.
module muldiv_seq #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;

  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     dsh, dtr;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign a_neg  = is_signed & a[WIDTH-1];
  assign b_neg  = is_signed & b[WIDTH-1];
  assign abs_a  = a_neg ? -a : a;
  assign abs_b  = b_neg ? -b : b;
  assign b_zero = (b == '0);

  // Multiply: add multiplicand into the upper half when LSB set, then shift right.
  assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {msum, acc_q[WIDTH-1:1]};

  // Divide: {rem,quo} shifts left; keep the trial difference when it does not borrow.
  assign dsh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign dtr = dsh - {1'b0, opnd_q};
  assign div_step = dtr[WIDTH]
    ? {dsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
    : {dtr[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                           : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      opnd_q <= '0;
      acc_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dz_q   <= 1'b0;
    end else begin
      op_q   <= op_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      opnd_q <= opnd_d;
      acc_q  <= acc_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      dz_q   <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = (op && b_zero) ? DONE : CALC;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d   = op_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    opnd_d = opnd_q;
    acc_d  = acc_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    dz_d   = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          neg_d = a_neg ^ b_neg;
          dz_d  = op && b_zero;
          if (op) begin
            opnd_d = abs_b;
            acc_d  = {{WIDTH{1'b0}}, abs_a};
            rneg_d = a_neg;
          end else begin
            opnd_d = abs_a;
            acc_d  = {{WIDTH{1'b0}}, abs_b};
            rneg_d = 1'b0;
          end
        end
      end
      CALC: acc_d = op_q ? div_step : mul_step;
      FIX: begin
        if (op_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      DONE: ;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC) || (state_q == FIX);
    done = (state_q == DONE);
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed cases plus random ops against an arithmetic model.
// A 32-bit and an 8-bit instance share stimulus; sel picks which one is driven.
module tb_muldiv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, op, is_signed, sel;
  logic [63:0] a_in, b_in;

  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  logic        busy_m, done_m, dz_m;
  logic [63:0] hi_m, lo_m;

  muldiv_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start & ~sel),
    .op(op), .is_signed(is_signed),
    .a(a_in[31:0]), .b(b_in[31:0]),
    .busy(busy32), .done(done32),
    .hi(hi32), .lo(lo32), .div_zero(dz32)
  );

  muldiv_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start & sel),
    .op(op), .is_signed(is_signed),
    .a(a_in[7:0]), .b(b_in[7:0]),
    .busy(busy8), .done(done8),
    .hi(hi8), .lo(lo8), .div_zero(dz8)
  );

  assign busy_m = sel ? busy8 : busy32;
  assign done_m = sel ? done8 : done32;
  assign dz_m   = sel ? dz8 : dz32;
  assign hi_m   = sel ? {56'd0, hi8} : {32'd0, hi32};
  assign lo_m   = sel ? {56'd0, lo8} : {32'd0, lo32};

  int checks = 0;
  int failures = 0;

  int          r_done_at, r_done_cnt, r_busy_cnt, r_busy_late;
  logic [63:0] r_hi, r_lo;
  logic        r_dz;

  // Signed/unsigned reference using plain 64-bit integer arithmetic.
  function automatic void model(input int w, input bit o, input bit sg,
                                input logic [63:0] av, input logic [63:0] bv,
                                output logic [63:0] eh, output logic [63:0] el);
    logic [63:0] mask, pu;
    longint x, y, p;
    mask = (64'd1 << w) - 64'd1;
    x = longint'(av & mask);
    y = longint'(bv & mask);
    if (sg && av[w-1]) x = x - longint'(64'd1 << w);
    if (sg && bv[w-1]) y = y - longint'(64'd1 << w);
    if (!o) begin
      p  = x * y;
      pu = p;
      el = pu & mask;
      eh = (pu >> w) & mask;
    end else begin
      pu = x / y;
      el = pu & mask;
      pu = x % y;
      eh = pu & mask;
    end
  endfunction

  task automatic run(input bit s, input bit o, input bit sg,
                     input logic [63:0] av, input logic [63:0] bv,
                     input int pulse_at);
    @(negedge clk);
    sel = s; op = o; is_signed = sg;
    a_in = av; b_in = bv; start = 1'b1;
    @(posedge clk);
    r_done_at = -1; r_done_cnt = 0;
    r_busy_cnt = 0; r_busy_late = 0;
    r_hi = '0; r_lo = '0; r_dz = 1'b0;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (j == 0) begin
        a_in = {$urandom, $urandom};
        b_in = {$urandom, $urandom};
        op = ~o; is_signed = ~sg;
      end
      start = (j == pulse_at);
      if (busy_m) begin
        r_busy_cnt++;
        if (r_done_at >= 0) r_busy_late++;
      end
      if (done_m) begin
        r_done_cnt++;
        if (r_done_at < 0) begin
          r_done_at = j; r_hi = hi_m; r_lo = lo_m; r_dz = dz_m;
        end
      end
      if (r_done_at >= 0 && j >= r_done_at + 4) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; sel = 1'b0;
    op = 1'b0; is_signed = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy32, done32, dz32, hi32, lo32} !== '0) begin
      failures++;
      $display("FAIL reset32 got=%h exp=0", {busy32, done32, dz32, hi32, lo32});
    end
    checks++;
    if ({busy8, done8, dz8, hi8, lo8} !== '0) begin
      failures++;
      $display("FAIL reset8 got=%h exp=0", {busy8, done8, dz8, hi8, lo8});
    end
    reset = 1'b0;
  endtask

  task automatic test_mult_signed();
    run(0, 0, 1, 64'h7, 64'hFFFFFFFD, -1);
    checks++;
    if (r_done_at !== 33 || r_done_cnt !== 1) begin
      failures++;
      $display("FAIL mul_lat got=%0d/%0d exp=33/1", r_done_at, r_done_cnt);
    end
    checks++;
    if (r_busy_cnt !== 33 || r_busy_late !== 0) begin
      failures++;
      $display("FAIL mul_busy got=%0d/%0d exp=33/0", r_busy_cnt, r_busy_late);
    end
    checks++;
    if (r_hi !== 64'hFFFFFFFF || r_lo !== 64'hFFFFFFEB || r_dz !== 1'b0) begin
      failures++;
      $display("FAIL mul_s got=%h_%h exp=ffffffff_ffffffeb", r_hi, r_lo);
    end
  endtask

  task automatic test_mult_max();
    run(0, 0, 0, 64'hFFFFFFFF, 64'hFFFFFFFF, -1);
    checks++;
    if (r_hi !== 64'hFFFFFFFE || r_lo !== 64'h1) begin
      failures++;
      $display("FAIL mul_umax got=%h_%h exp=fffffffe_1", r_hi, r_lo);
    end
    run(0, 0, 1, 64'hFFFFFFFF, 64'hFFFFFFFF, -1);
    checks++;
    if (r_hi !== 64'h0 || r_lo !== 64'h1) begin
      failures++;
      $display("FAIL mul_smax got=%h_%h exp=0_1", r_hi, r_lo);
    end
  endtask

  task automatic test_div();
    run(0, 1, 1, 64'hFFFFFFF9, 64'h2, -1);
    checks++;
    if (r_done_at !== 33 || r_hi !== 64'hFFFFFFFF || r_lo !== 64'hFFFFFFFD) begin
      failures++;
      $display("FAIL div_s got=%0d %h_%h exp=33 ffffffff_fffffffd",
               r_done_at, r_hi, r_lo);
    end
    run(0, 1, 0, 64'd100, 64'd7, -1);
    checks++;
    if (r_hi !== 64'd2 || r_lo !== 64'd14) begin
      failures++;
      $display("FAIL div_u got=%h_%h exp=2_e", r_hi, r_lo);
    end
  endtask

  task automatic test_div_zero();
    run(0, 1, 0, 64'd5, 64'd0, -1);
    checks++;
    if (r_done_at !== 0 || r_done_cnt !== 1 || r_busy_cnt !== 0) begin
      failures++;
      $display("FAIL dz_lat got=%0d/%0d/%0d exp=0/1/0",
               r_done_at, r_done_cnt, r_busy_cnt);
    end
    checks++;
    if (r_dz !== 1'b1 || r_hi !== 64'd2 || r_lo !== 64'd14) begin
      failures++;
      $display("FAIL dz_hold got=%b %h_%h exp=1 2_e", r_dz, r_hi, r_lo);
    end
    run(0, 0, 0, 64'd3, 64'd4, -1);
    checks++;
    if (r_dz !== 1'b0 || r_lo !== 64'd12 || r_hi !== 64'd0) begin
      failures++;
      $display("FAIL dz_clear got=%b %h_%h exp=0 0_c", r_dz, r_hi, r_lo);
    end
  endtask

  task automatic test_overflow_busy_start();
    run(0, 1, 1, 64'h80000000, 64'hFFFFFFFF, 4);
    checks++;
    if (r_lo !== 64'h80000000 || r_hi !== 64'h0) begin
      failures++;
      $display("FAIL div_ovf got=%h_%h exp=0_80000000", r_hi, r_lo);
    end
    checks++;
    if (r_done_cnt !== 1 || r_done_at !== 33 || r_busy_late !== 0) begin
      failures++;
      $display("FAIL busy_start got=%0d/%0d/%0d exp=1/33/0",
               r_done_cnt, r_done_at, r_busy_late);
    end
  endtask

  task automatic test_reset_mid();
    int dcnt;
    dcnt = 0;
    @(negedge clk);
    sel = 1'b0; op = 1'b0; is_signed = 1'b1;
    a_in = 64'd9; b_in = 64'd9; start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (done32) dcnt++;
      if (j == 9) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy32, done32, hi32, lo32} !== '0) begin
      failures++;
      $display("FAIL rst_mid got=%h exp=0", {busy32, done32, hi32, lo32});
    end
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (done32 || busy32) dcnt++;
    end
    checks++;
    if (dcnt !== 0) begin
      failures++;
      $display("FAIL rst_nodone got=%0d exp=0", dcnt);
    end
  endtask

  task automatic test_width8();
    run(1, 0, 1, 64'h80, 64'h80, -1);
    checks++;
    if (r_done_at !== 9 || r_busy_cnt !== 9 || r_done_cnt !== 1) begin
      failures++;
      $display("FAIL w8_lat got=%0d/%0d/%0d exp=9/9/1",
               r_done_at, r_busy_cnt, r_done_cnt);
    end
    checks++;
    if (r_hi !== 64'h40 || r_lo !== 64'h0) begin
      failures++;
      $display("FAIL w8_mul got=%h_%h exp=40_0", r_hi, r_lo);
    end
  endtask

  task automatic test_random();
    logic [63:0] ph [2];
    logic [63:0] pl [2];
    logic [63:0] av, bv, eh, el, mask;
    bit s, o, sg, z;
    int w, elat;
    ph[0] = 64'h0;  pl[0] = 64'h0;
    ph[1] = 64'h40; pl[1] = 64'h0;
    for (int n = 0; n < 40; n++) begin
      s  = ($urandom_range(3) == 0);
      o  = $urandom_range(1);
      sg = $urandom_range(1);
      w  = s ? 8 : 32;
      mask = (64'd1 << w) - 64'd1;
      av = {32'd0, $urandom} & mask;
      bv = {32'd0, $urandom} & mask;
      if ($urandom_range(7) == 0) bv = '0;
      z = o && (bv == 0);
      if (z) begin
        eh = ph[s]; el = pl[s]; elat = 0;
      end else begin
        model(w, o, sg, av, bv, eh, el);
        ph[s] = eh; pl[s] = el; elat = w + 1;
      end
      run(s, o, sg, av, bv, -1);
      checks++;
      if (r_done_at !== elat || r_done_cnt !== 1 || r_hi !== eh
          || r_lo !== el || r_dz !== z) begin
        failures++;
        $display("FAIL rand w=%0d op=%0d s=%0d a=%h b=%h got=%0d %h_%h dz=%b exp=%0d %h_%h dz=%b",
                 w, o, sg, av, bv, r_done_at, r_hi, r_lo, r_dz,
                 elat, eh, el, z);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_mult_max();
    test_div();
    test_div_zero();
    test_overflow_busy_start();
    test_reset_mid();
    test_width8();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
